// File: rtl/ahblite_slave_mux.sv
// ahblite_slave_mux
//   Response-side mux that sits after the AHB-Lite address decoder.
//   The decoder's port selects are captured in the address phase and held
//   for the data phase. They steer the owning slave's HREADYOUT/HRESP/HRDATA
//   back to the master. Transfers that hit no port go to a built-in
//   default slave. It answers active transfers with the two-cycle ERROR
//   response, or with zero-wait OKAY when ERR_EN=0.
//
// Ports
//   HCLK, HRESETn             clock, asynchronous active-low reset
//   HTRANS[1:0]               transfer type of the current address phase
//   Pn_HSEL                   decoder selects (address phase), n = 0..4
//   Pn_HREADYOUT/HRESP/HRDATA slave responses (data phase)
//   HREADY, HRESP, HRDATA     muxed bus response; HREADY also feeds back
//                             to the slaves and the master

// One response lane. It gates a slave's response with its data-phase
// select, so the top module can OR the lanes together.
module ahblite_slave_mux_lane (
    input  logic        sel,
    input  logic        hreadyout,
    input  logic        hresp,
    input  logic [31:0] hrdata,
    output logic        ready,
    output logic        resp,
    output logic [31:0] rdata
);
    assign ready = sel & hreadyout;
    assign resp  = sel & hresp;
    assign rdata = {32{sel}} & hrdata;
endmodule

module ahblite_slave_mux #(
    parameter logic [31:0] DEFAULT_RDATA = 32'h0000_0000,
    parameter bit          ERR_EN        = 1'b1
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [1:0]  HTRANS,
    input  logic        P0_HSEL,
    input  logic        P1_HSEL,
    input  logic        P2_HSEL,
    input  logic        P3_HSEL,
    input  logic        P4_HSEL,
    input  logic        P0_HREADYOUT,
    input  logic        P1_HREADYOUT,
    input  logic        P2_HREADYOUT,
    input  logic        P3_HREADYOUT,
    input  logic        P4_HREADYOUT,
    input  logic        P0_HRESP,
    input  logic        P1_HRESP,
    input  logic        P2_HRESP,
    input  logic        P3_HRESP,
    input  logic        P4_HRESP,
    input  logic [31:0] P0_HRDATA,
    input  logic [31:0] P1_HRDATA,
    input  logic [31:0] P2_HRDATA,
    input  logic [31:0] P3_HRDATA,
    input  logic [31:0] P4_HRDATA,
    output logic        HREADY,
    output logic        HRESP,
    output logic [31:0] HRDATA
);
    localparam int NUM_PORTS = 5;
    localparam int DEF       = NUM_PORTS;   // index of the default slave in the select vectors

    // The encoding gives the outputs directly: bit1 is HRESP and bit0 is
    // "not ready". The FSM outputs are therefore registered without
    // extra flops.
    typedef enum logic [1:0] {
        DS_IDLE = 2'b00,
        DS_ERR2 = 2'b10,
        DS_ERR1 = 2'b11
    } ds_state_t;

    logic [NUM_PORTS-1:0]        hsel, hreadyout, hresp;
    logic [NUM_PORTS-1:0][31:0]  hrdata;
    logic [NUM_PORTS:0]          addr_sel;
    logic [NUM_PORTS:0]          dp_sel;
    logic                        dp_act;
    ds_state_t                   ds_state;

    logic [NUM_PORTS-1:0]        lane_ready, lane_resp;
    logic [NUM_PORTS-1:0][31:0]  lane_rdata;
    logic [31:0]                 rdata_or;
    logic                        htrans_active;
    logic                        err_start;
    logic                        def_ready, def_resp;

    assign hsel      = {P4_HSEL, P3_HSEL, P2_HSEL, P1_HSEL, P0_HSEL};
    assign hreadyout = {P4_HREADYOUT, P3_HREADYOUT, P2_HREADYOUT, P1_HREADYOUT, P0_HREADYOUT};
    assign hresp     = {P4_HRESP, P3_HRESP, P2_HRESP, P1_HRESP, P0_HRESP};
    assign hrdata    = {P4_HRDATA, P3_HRDATA, P2_HRDATA, P1_HRDATA, P0_HRDATA};

    // NONSEQ or SEQ
    assign htrans_active = (HTRANS == 2'b10) || (HTRANS == 2'b11);

    // One-hot address-phase select. The loop runs downward, so the lowest
    // port that is selected wins. If no select is high, DEF takes the
    // transfer.
    always_comb begin
        addr_sel      = '0;
        addr_sel[DEF] = 1'b1;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (hsel[i]) begin
                addr_sel    = '0;
                addr_sel[i] = 1'b1;
            end
        end
    end

    // Data-phase owner. It advances only when the bus accepts the
    // address phase, so it holds through slave wait states.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_sel <= (NUM_PORTS+1)'(1) << DEF;
            dp_act <= 1'b0;
        end else if (HREADY) begin
            dp_sel <= addr_sel;
            dp_act <= htrans_active;
        end
    end

    // Default slave. A new error starts only when an active transfer to
    // unmapped space is accepted. It can do so from ERR2, which lets
    // back-to-back errors chain with no idle cycle between them.
    assign err_start = HREADY & addr_sel[DEF] & htrans_active & ERR_EN;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ds_state <= DS_IDLE;
        end else begin
            case (ds_state)
                DS_IDLE: ds_state <= err_start ? DS_ERR1 : DS_IDLE;
                DS_ERR1: ds_state <= DS_ERR2;
                DS_ERR2: ds_state <= err_start ? DS_ERR1 : DS_IDLE;
                default: ds_state <= DS_IDLE;
            endcase
        end
    end

    // The error states are only ever entered with an active data phase.
    // Qualifying with dp_act guarantees that an idle default data phase
    // can never show ERROR.
    assign def_ready = ~ds_state[0];
    assign def_resp  = ds_state[1] & dp_act;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_lane
        ahblite_slave_mux_lane u_lane (
            .sel       (dp_sel[g]),
            .hreadyout (hreadyout[g]),
            .hresp     (hresp[g]),
            .hrdata    (hrdata[g]),
            .ready     (lane_ready[g]),
            .resp      (lane_resp[g]),
            .rdata     (lane_rdata[g])
        );
    end

    always_comb begin
        rdata_or = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            rdata_or = rdata_or | lane_rdata[i];
        end
    end

    // dp_sel is one-hot, so an AND-OR mux is enough.
    assign HREADY = (|lane_ready) | (dp_sel[DEF] & def_ready);
    assign HRESP  = (|lane_resp)  | (dp_sel[DEF] & def_resp);
    assign HRDATA = rdata_or | (dp_sel[DEF] ? DEFAULT_RDATA : 32'h0);

endmodule

// File: tb/tb_ahblite_slave_mux.sv
module tb_ahblite_slave_mux;
    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        htrans;
    logic [4:0]        hsel, rdy, rsp;
    logic [4:0][31:0]  prd;
    logic              hready, hresp, hready_ne, hresp_ne;
    logic [31:0]       hrdata, hrdata_ne;

    int errors = 0;
    int checks = 0;
    int multi_cnt = 0;

    always #5 clk = ~clk;

    ahblite_slave_mux #(.DEFAULT_RDATA(32'h0), .ERR_EN(1'b1)) dut (
        .HCLK(clk), .HRESETn(rst_n), .HTRANS(htrans),
        .P0_HSEL(hsel[0]), .P1_HSEL(hsel[1]), .P2_HSEL(hsel[2]), .P3_HSEL(hsel[3]), .P4_HSEL(hsel[4]),
        .P0_HREADYOUT(rdy[0]), .P1_HREADYOUT(rdy[1]), .P2_HREADYOUT(rdy[2]),
        .P3_HREADYOUT(rdy[3]), .P4_HREADYOUT(rdy[4]),
        .P0_HRESP(rsp[0]), .P1_HRESP(rsp[1]), .P2_HRESP(rsp[2]), .P3_HRESP(rsp[3]), .P4_HRESP(rsp[4]),
        .P0_HRDATA(prd[0]), .P1_HRDATA(prd[1]), .P2_HRDATA(prd[2]), .P3_HRDATA(prd[3]), .P4_HRDATA(prd[4]),
        .HREADY(hready), .HRESP(hresp), .HRDATA(hrdata)
    );

    ahblite_slave_mux #(.DEFAULT_RDATA(32'h0), .ERR_EN(1'b0)) dut_ne (
        .HCLK(clk), .HRESETn(rst_n), .HTRANS(htrans),
        .P0_HSEL(hsel[0]), .P1_HSEL(hsel[1]), .P2_HSEL(hsel[2]), .P3_HSEL(hsel[3]), .P4_HSEL(hsel[4]),
        .P0_HREADYOUT(rdy[0]), .P1_HREADYOUT(rdy[1]), .P2_HREADYOUT(rdy[2]),
        .P3_HREADYOUT(rdy[3]), .P4_HREADYOUT(rdy[4]),
        .P0_HRESP(rsp[0]), .P1_HRESP(rsp[1]), .P2_HRESP(rsp[2]), .P3_HRESP(rsp[3]), .P4_HRESP(rsp[4]),
        .P0_HRDATA(prd[0]), .P1_HRDATA(prd[1]), .P2_HRDATA(prd[2]), .P3_HRDATA(prd[3]), .P4_HRDATA(prd[4]),
        .HREADY(hready_ne), .HRESP(hresp_ne), .HRDATA(hrdata_ne)
    );

    // Decoder-fault monitor: more than one HSEL in an accepted address phase
    always @(posedge clk) begin
        if (rst_n && hready && ($countones(hsel) > 1)) begin
            multi_cnt++;
            $display("note: decoder fault, multiple HSEL %b at %0t", hsel, $time);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [4:0]  hsel;
        logic [1:0]  htrans;
        logic [4:0]  rdy;
        logic [4:0]  rsp;
        logic        er, ep;      // expected HREADY/HRESP, ERR_EN=1
        logic [31:0] ed;
        logic        nr, np;      // expected HREADY/HRESP, ERR_EN=0
        logic [31:0] nd;
    } vec_t;

    function automatic vec_t v(logic [4:0] s, logic [1:0] t, logic [4:0] r, logic [4:0] p,
                               logic er, logic ep, logic [31:0] ed,
                               logic nr, logic np, logic [31:0] nd);
        vec_t x;
        x.hsel = s; x.htrans = t; x.rdy = r; x.rsp = p;
        x.er = er; x.ep = ep; x.ed = ed; x.nr = nr; x.np = np; x.nd = nd;
        return x;
    endfunction

    // Inputs are applied just after the rising edge and outputs are
    // checked on the falling edge. The task returns 1ns after the next
    // rising edge.
    task automatic run_vec(input int idx, input vec_t t);
        hsel = t.hsel; htrans = t.htrans; rdy = t.rdy; rsp = t.rsp;
        @(negedge clk);
        chk($sformatf("v%0d hready", idx),    {31'h0, hready},    {31'h0, t.er});
        chk($sformatf("v%0d hresp", idx),     {31'h0, hresp},     {31'h0, t.ep});
        chk($sformatf("v%0d hrdata", idx),    hrdata,             t.ed);
        chk($sformatf("v%0d hready_ne", idx), {31'h0, hready_ne}, {31'h0, t.nr});
        chk($sformatf("v%0d hresp_ne", idx),  {31'h0, hresp_ne},  {31'h0, t.np});
        chk($sformatf("v%0d hrdata_ne", idx), hrdata_ne,          t.nd);
        @(posedge clk);
        #1;
    endtask

    // Reference model. It tracks who owns the data phase and how many
    // cycles that data phase has lasted. An active transfer to the default
    // slave with errors enabled gives one cycle of not-ready ERROR, then
    // one ready ERROR cycle.
    int m_owner[2];
    bit m_act[2];
    int m_ph[2];

    function automatic int prio(logic [4:0] s);
        for (int i = 0; i < 5; i++) if (s[i]) return i;
        return 5;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin m_owner[k] = 5; m_act[k] = 0; m_ph[k] = 0; end
    endtask

    task automatic rnd_cycle(input int cyc);
        logic        er[2], ep[2];
        logic [31:0] ed[2];
        int r;
        r = $urandom_range(0, 5);
        hsel   = (r == 5) ? 5'b0 : (5'b1 << r);
        htrans = 2'($urandom_range(0, 3));
        for (int i = 0; i < 5; i++) begin
            rdy[i] = ($urandom_range(0, 3) != 0);
            rsp[i] = ($urandom_range(0, 7) == 0);
            prd[i] = $urandom;
        end
        for (int k = 0; k < 2; k++) begin
            if (m_owner[k] < 5) begin
                er[k] = rdy[m_owner[k]]; ep[k] = rsp[m_owner[k]]; ed[k] = prd[m_owner[k]];
            end else if (k == 0 && m_act[k]) begin
                er[k] = (m_ph[k] >= 2); ep[k] = 1'b1; ed[k] = 32'h0;
            end else begin
                er[k] = 1'b1; ep[k] = 1'b0; ed[k] = 32'h0;
            end
        end
        @(negedge clk);
        chk($sformatf("rnd%0d hready", cyc),    {31'h0, hready},    {31'h0, er[0]});
        chk($sformatf("rnd%0d hresp", cyc),     {31'h0, hresp},     {31'h0, ep[0]});
        chk($sformatf("rnd%0d hrdata", cyc),    hrdata,             ed[0]);
        chk($sformatf("rnd%0d hready_ne", cyc), {31'h0, hready_ne}, {31'h0, er[1]});
        chk($sformatf("rnd%0d hresp_ne", cyc),  {31'h0, hresp_ne},  {31'h0, ep[1]});
        chk($sformatf("rnd%0d hrdata_ne", cyc), hrdata_ne,          ed[1]);
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (er[k]) begin
                m_owner[k] = prio(hsel); m_act[k] = htrans[1]; m_ph[k] = 1;
            end else begin
                m_ph[k]++;
            end
        end
        #1;
    endtask

    localparam logic [1:0] IDLE = 2'b00, NSEQ = 2'b10;
    vec_t tbl[27];

    initial begin
        tbl[0]  = v(5'b00001, NSEQ, 5'h1f, 5'h0, 1, 0, 32'h0,        1, 0, 32'h0);
        tbl[1]  = v(5'b00000, IDLE, 5'h1f, 5'h0, 1, 0, 32'hDEADBEEF, 1, 0, 32'hDEADBEEF);
        tbl[2]  = v(5'b00100, NSEQ, 5'h1f, 5'h0, 1, 0, 32'h0,        1, 0, 32'h0);
        tbl[3]  = v(5'b01000, NSEQ, 5'h1b, 5'h0, 0, 0, 32'h22222222, 0, 0, 32'h22222222);
        tbl[4]  = v(5'b01000, NSEQ, 5'h1b, 5'h0, 0, 0, 32'h22222222, 0, 0, 32'h22222222);
        tbl[5]  = v(5'b01000, NSEQ, 5'h1b, 5'h0, 0, 0, 32'h22222222, 0, 0, 32'h22222222);
        tbl[6]  = v(5'b01000, NSEQ, 5'h1f, 5'h0, 1, 0, 32'h22222222, 1, 0, 32'h22222222);
        tbl[7]  = v(5'b00000, IDLE, 5'h1f, 5'h0, 1, 0, 32'h1,        1, 0, 32'h1);
        tbl[8]  = v(5'b00000, NSEQ, 5'h1f, 5'h0, 1, 0, 32'h0,        1, 0, 32'h0);
        tbl[9]  = v(5'b00000, IDLE, 5'h1f, 5'h0, 0, 1, 32'h0,        1, 0, 32'h0);
        tbl[10] = v(5'b00000, IDLE, 5'h1f, 5'h0, 1, 1, 32'h0,        1, 0, 32'h0);
        tbl[11] = v(5'b00000, IDLE, 5'h1f, 5'h0, 1, 0, 32'h0,        1, 0, 32'h0);
        tbl[12] = v(5'b00000, NSEQ, 5'h1f, 5'h0, 1, 0, 32'h0,        1, 0, 32'h0);
        tbl[13] = v(5'b00000, NSEQ, 5'h1f, 5'h0, 0, 1, 32'h0,        1, 0, 32'h0);
        tbl[14] = v(5'b00000, NSEQ, 5'h1f, 5'h0, 1, 1, 32'h0,        1, 0, 32'h0);
        tbl[15] = v(5'b00000, IDLE, 5'h1f, 5'h0, 0, 1, 32'h0,        1, 0, 32'h0);
        tbl[16] = v(5'b00000, IDLE, 5'h1f, 5'h0, 1, 1, 32'h0,        1, 0, 32'h0);
        tbl[17] = v(5'b00000, IDLE, 5'h1f, 5'h0, 1, 0, 32'h0,        1, 0, 32'h0);
        tbl[18] = v(5'b00000, NSEQ, 5'h1f, 5'h0, 1, 0, 32'h0,        1, 0, 32'h0);
        tbl[19] = v(5'b00010, NSEQ, 5'h1f, 5'h0, 1, 0, 32'h0,        1, 0, 32'h0);
        tbl[20] = v(5'b00000, IDLE, 5'h1f, 5'h0, 1, 0, 32'hA5A5A5A5, 1, 0, 32'hA5A5A5A5);
        tbl[21] = v(5'b10001, NSEQ, 5'h1f, 5'h0, 1, 0, 32'h0,        1, 0, 32'h0);
        tbl[22] = v(5'b00000, IDLE, 5'h1f, 5'h0, 1, 0, 32'hDEADBEEF, 1, 0, 32'hDEADBEEF);
        tbl[23] = v(5'b10000, NSEQ, 5'h1f, 5'h0, 1, 0, 32'h0,        1, 0, 32'h0);
        tbl[24] = v(5'b00000, IDLE, 5'h0f, 5'h10, 0, 1, 32'h44444444, 0, 1, 32'h44444444);
        tbl[25] = v(5'b00000, IDLE, 5'h1f, 5'h10, 1, 1, 32'h44444444, 1, 1, 32'h44444444);
        tbl[26] = v(5'b00000, IDLE, 5'h1f, 5'h0, 1, 0, 32'h0,        1, 0, 32'h0);

        prd[0] = 32'hDEADBEEF; prd[1] = 32'hA5A5A5A5; prd[2] = 32'h22222222;
        prd[3] = 32'h00000001; prd[4] = 32'h44444444;
        hsel = '0; htrans = IDLE; rdy = '1; rsp = '0;

        // Reset state
        rst_n = 1'b0;
        #12;
        chk("reset hready", {31'h0, hready}, 32'h1);
        chk("reset hresp",  {31'h0, hresp},  32'h0);
        chk("reset hrdata", hrdata, 32'h0);
        chk("reset hready_ne", {31'h0, hready_ne}, 32'h1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 27; i++) begin
            if (i == 19) begin
                // Take the reset while the default slave is in its first
                // error cycle (entered on the edge that ended tbl[18]).
                hsel = '0; htrans = IDLE; rdy = '1; rsp = '0;
                #2;
                chk("err1 before reset hready", {31'h0, hready}, 32'h0);
                chk("err1 before reset hresp",  {31'h0, hresp},  32'h1);
                rst_n = 1'b0;
                #1;
                chk("async reset hready", {31'h0, hready}, 32'h1);
                chk("async reset hresp",  {31'h0, hresp},  32'h0);
                chk("async reset hrdata", hrdata, 32'h0);
                @(posedge clk); #1;
                rst_n = 1'b1;
            end
            run_vec(i, tbl[i]);
            if (i == 22) chk("multi hsel flagged", 32'(multi_cnt), 32'h1);
        end

        // Randomized run against the reference model
        hsel = '0; htrans = IDLE; rdy = '1; rsp = '0;
        rst_n = 1'b0;
        #2;
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 300; c++) rnd_cycle(c);

        chk("no stray multi hsel", 32'(multi_cnt), 32'h1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ahblite_slave_mux.md
Name: ahblite_slave_mux

Overview:
- Response-side stage directly downstream of the AHB-Lite address decoder.
- Captures the five port selects in the address phase and holds them through the data phase.
- Routes the selected slave's HRDATA/HREADYOUT/HRESP back to the Cortex-M0 bus.
- Contains a built-in default slave that returns a two-cycle AHB ERROR response for active transfers to unmapped addresses.

Parameters:
- DEFAULT_RDATA, 32'h0000_0000, HRDATA value driven when no port owns the data phase.
- ERR_EN, 1, 1: default slave returns ERROR for unmapped NONSEQ/SEQ; 0: zero-wait OKAY instead.

Ports:
- HCLK  input  1  bus clock
- HRESETn  input  1  asynchronous active-low reset
- HTRANS  input  2  master transfer type of the current address phase
- P0_HSEL..P4_HSEL  input  1 each  port selects from the decoder (address phase)
- P0_HREADYOUT..P4_HREADYOUT  input  1 each  slave ready
- P0_HRESP..P4_HRESP  input  1 each  slave response (0 OKAY, 1 ERROR)
- P0_HRDATA..P4_HRDATA  input  32 each  slave read data
- HREADY  output  1  bus ready, also fed back to all slaves and the master
- HRESP  output  1  bus response
- HRDATA  output  32  bus read data

Behaviour:
- Clock and reset: one clock, HCLK. HRESETn is asynchronous and active-low.
- Address-phase select vector: addr_sel[5:0] is one-hot {DEF, P4..P0}.
  - Pn is chosen if PnHSEL=1, with fixed priority P0 > P1 > ... > P4 when several are high.
  - DEF is chosen if no PnHSEL is high.
- Data-phase register: dp_sel[5:0] loads addr_sel on rising HCLK only when HREADY=1. When HREADY=0 it holds.
- Active flag: dp_act loads HTRANS[1] under the same HREADY=1 condition.
- Output mux, driven combinationally from dp_sel:
  - Pn owns the data phase: HREADY=PnHREADYOUT, HRESP=PnHRESP, HRDATA=PnHRDATA. There is no added latency.
  - DEF owns the data phase: HRDATA=DEFAULT_RDATA; HREADY and HRESP come from the default-slave FSM.
- Default-slave FSM (states DS_IDLE, DS_ERR1, DS_ERR2):
  - DS_IDLE: HREADY=1, HRESP=0.
    - Go to DS_ERR1 on a rising edge where HREADY=1, addr_sel[DEF]=1, HTRANS[1]=1 and ERR_EN=1.
    - Otherwise stay in DS_IDLE. IDLE/BUSY transfers to unmapped space get zero-wait OKAY.
  - DS_ERR1: HREADY=0, HRESP=1. Always go to DS_ERR2 next cycle.
  - DS_ERR2: HREADY=1, HRESP=1.
    - Go to DS_ERR1 if another active unmapped transfer is being accepted in this cycle (back-to-back errors).
    - Otherwise go to DS_IDLE.
  - HRESP is held constant across both error cycles, as AHB requires.
- Reset values (asynchronous on HRESETn=0):
  - dp_sel=6'b100000 (DEF), dp_act=0, FSM=DS_IDLE.
  - Outputs therefore: HREADY=1, HRESP=0, HRDATA=DEFAULT_RDATA.
- Boundary conditions:
  - Wait states: while the selected slave drives HREADYOUT=0, dp_sel holds and the next address phase is not sampled.
  - Slave switch: a transfer to Pn immediately following a transfer to Pm switches the mux on the same edge the Pm data phase completes. There is no bubble.
  - Reset mid-error: asserting HRESETn during DS_ERR1 forces DS_IDLE and HREADY=1 immediately. After deassertion the first transfer is decoded normally.
  - Multiple HSEL: resolved by priority. This is a decoder fault; the bench flags it as an assertion error.
- Implementation: sequential elements are dp_sel, dp_act and the 2-bit FSM only. No combinational path runs from HRDATA inputs to any register.

Test Plan:
1. Reset, then NONSEQ read at 0x0000_0010 with P0_HSEL=1; P0 returns HREADYOUT=1, HRDATA=32'hDEADBEEF. Expect the next cycle to show HRDATA=DEADBEEF, HREADY=1, HRESP=0.
2. Write to P2 (0x4005_0000) where P2 holds HREADYOUT=0 for 3 cycles, with a P3 transfer (0x4000_0014) pipelined behind it. Expect:
   - HREADY=0 for 3 cycles, with dp_sel stable at P2;
   - the mux switches to P3 on the 4th edge;
   - P3_HRDATA=32'h1 appears the following cycle.
3. NONSEQ to 0x3000_0000, no HSEL high. Expect cycle1 HREADY=0/HRESP=1, cycle2 HREADY=1/HRESP=1, then OKAY. Repeat with HTRANS=IDLE: expect zero-wait OKAY, HRDATA=0.
4. Two consecutive unmapped NONSEQs. Expect the ERR1, ERR2, ERR1, ERR2 sequence with HRESP=1 throughout, then DS_IDLE. With ERR_EN=0, expect both complete as zero-wait OKAY.
5. Assert HRESETn=0 during DS_ERR1. Expect HREADY=1, HRESP=0 asynchronously; after release, a P1 read (0x2000_0004) returns P1_HRDATA=32'hA5A5A5A5 with OKAY.
6. Assert P0_HSEL and P4_HSEL together. Expect P0 data routed and the bench assertion fired.
